// File: rtl/player_motion.sv
// player_motion: latches decoded D-pad buttons and steps the player X/Y
// position on a programmable frame tick, clamping or wrapping at the
// playfield edges.
// Optional build macro PLAYER_MOTION_ACCEL_EN: per-axis hold counters that
// double the step after the same direction has been held for several ticks.
module player_motion #(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 416667,
  parameter int WRAP     = 0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Enable,
  input  logic           Recenter,
  input  logic           Readable,
  input  logic           Up,
  input  logic           Down,
  input  logic           Left,
  input  logic           Right,
  output logic [X_W-1:0] X,
  output logic [Y_W-1:0] Y,
  output logic           Tick,
  output logic           Moving
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Edge arithmetic is done one bit wider than the coordinate so that
  // pos+step and pos+span never overflow before the edge decision.
  localparam logic [X_W:0] X_MAX_E = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] X_SPAN  = (X_W+1)'(X_MAX + 1);
  localparam logic [X_W:0] X_STEP1 = (X_W+1)'(STEP);
  localparam logic [Y_W:0] Y_MAX_E = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] Y_SPAN  = (Y_W+1)'(Y_MAX + 1);
  localparam logic [Y_W:0] Y_STEP1 = (Y_W+1)'(STEP);

  // Latched buttons, ordered {Up, Down, Left, Right}
  logic [3:0]       r_btn;
  logic [CNT_W-1:0] r_cnt;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_tick;
  logic             r_moving;

  logic             w_tick_int;
  logic             w_x_inc, w_x_dec, w_y_inc, w_y_dec;
  logic [X_W:0]     w_x_ext, w_x_sum, w_x_step;
  logic [Y_W:0]     w_y_ext, w_y_sum, w_y_step;
  logic [X_W-1:0]   w_x_next;
  logic [Y_W-1:0]   w_y_next;

  assign w_tick_int = Enable && (r_cnt == CNT_LAST);

  // Opposing buttons on an axis cancel each other out
  assign w_x_inc = r_btn[0] & ~r_btn[1];
  assign w_x_dec = r_btn[1] & ~r_btn[0];
  assign w_y_inc = r_btn[2] & ~r_btn[3];
  assign w_y_dec = r_btn[3] & ~r_btn[2];

`ifdef PLAYER_MOTION_ACCEL_EN
  localparam logic [X_W:0] X_STEP2 = (X_W+1)'(2 * STEP);
  localparam logic [Y_W:0] Y_STEP2 = (Y_W+1)'(2 * STEP);

  // Hold count and last moving direction per axis; direction is {inc, dec}
  logic [2:0] r_x_hold, r_y_hold;
  logic [1:0] r_x_dir,  r_y_dir;

  assign w_x_step = (r_x_hold >= 3'd4) ? X_STEP2 : X_STEP1;
  assign w_y_step = (r_y_hold >= 3'd4) ? Y_STEP2 : Y_STEP1;

  // Hold counters: count consecutive same-direction ticks, saturating at 7
  always_ff @(posedge CLK) begin
    if (RST || Recenter) begin
      r_x_hold <= '0;
      r_y_hold <= '0;
      r_x_dir  <= '0;
      r_y_dir  <= '0;
    end else if (w_tick_int) begin
      r_x_dir <= {w_x_inc, w_x_dec};
      r_y_dir <= {w_y_inc, w_y_dec};
      if (({w_x_inc, w_x_dec} != 2'b00) && ({w_x_inc, w_x_dec} == r_x_dir)) begin
        if (r_x_hold != 3'd7) r_x_hold <= r_x_hold + 3'd1;
      end else begin
        r_x_hold <= '0;
      end
      if (({w_y_inc, w_y_dec} != 2'b00) && ({w_y_inc, w_y_dec} == r_y_dir)) begin
        if (r_y_hold != 3'd7) r_y_hold <= r_y_hold + 3'd1;
      end else begin
        r_y_hold <= '0;
      end
    end
  end
`else
  assign w_x_step = X_STEP1;
  assign w_y_step = Y_STEP1;
`endif

  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};
  assign w_x_sum = w_x_ext + w_x_step;
  assign w_y_sum = w_y_ext + w_y_step;

  // Next X: step toward the pressed side, then clamp or wrap at the edges
  always_comb begin
    w_x_next = r_x;
    if (w_x_inc) begin
      if (w_x_sum > X_MAX_E)
        w_x_next = (WRAP != 0) ? X_W'(w_x_sum - X_SPAN) : X_W'(X_MAX_E);
      else
        w_x_next = X_W'(w_x_sum);
    end else if (w_x_dec) begin
      if (w_x_ext < w_x_step)
        w_x_next = (WRAP != 0) ? X_W'(w_x_ext + X_SPAN - w_x_step) : '0;
      else
        w_x_next = X_W'(w_x_ext - w_x_step);
    end
  end

  // Next Y: Down increments, Up decrements, same edge handling as X
  always_comb begin
    w_y_next = r_y;
    if (w_y_inc) begin
      if (w_y_sum > Y_MAX_E)
        w_y_next = (WRAP != 0) ? Y_W'(w_y_sum - Y_SPAN) : Y_W'(Y_MAX_E);
      else
        w_y_next = Y_W'(w_y_sum);
    end else if (w_y_dec) begin
      if (w_y_ext < w_y_step)
        w_y_next = (WRAP != 0) ? Y_W'(w_y_ext + Y_SPAN - w_y_step) : '0;
      else
        w_y_next = Y_W'(w_y_ext - w_y_step);
    end
  end

  // Button latch, prescaler, and position update with RST > Recenter > tick
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_btn    <= '0;
      r_cnt    <= '0;
      r_x      <= X_W'(X_INIT);
      r_y      <= Y_W'(Y_INIT);
      r_tick   <= 1'b0;
      r_moving <= 1'b0;
    end else begin
      if (Readable) r_btn <= {Up, Down, Left, Right};

      if (!Enable || w_tick_int) r_cnt <= '0;
      else                       r_cnt <= r_cnt + CNT_W'(1);

      r_tick <= w_tick_int & ~Recenter;

      if (Recenter) begin
        r_x <= X_W'(X_INIT);
        r_y <= Y_W'(Y_INIT);
      end else if (w_tick_int) begin
        r_x      <= w_x_next;
        r_y      <= w_y_next;
        r_moving <= (w_x_next != r_x) || (w_y_next != r_y);
      end
    end
  end

  assign X      = r_x;
  assign Y      = r_y;
  assign Tick   = r_tick;
  assign Moving = r_moving;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: four instances with different
// parameter sets (default centre, clamp near right edge, wrap with STEP=3,
// acceleration start at X=100), each driven from its own input bits.
module tb_player_motion;

  localparam int NI = 4;
  localparam int XI [NI] = '{320, 636, 638, 100};
  localparam int YI [NI] = '{240, 240,   1, 240};
  localparam int ST [NI] = '{  1,   1,   3,   1};
  localparam int WR [NI] = '{  0,   0,   1,   0};

`ifdef PLAYER_MOTION_ACCEL_EN
  localparam int HOLD_X [6] = '{101, 102, 103, 104, 105, 107};
`else
  localparam int HOLD_X [6] = '{101, 102, 103, 104, 105, 106};
`endif

  logic clk;
  logic [NI-1:0] rst, en, rc, rd, bu, bd, bl, br;
  logic [9:0] xs [NI];
  logic [9:0] ys [NI];
  logic       tk [NI];
  logic       mv [NI];

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    player_motion #(
      .X_W(10), .Y_W(10), .X_MAX(639), .Y_MAX(479),
      .X_INIT(XI[g]), .Y_INIT(YI[g]), .STEP(ST[g]),
      .TICK_DIV(4), .WRAP(WR[g])
    ) u_dut (
      .CLK(clk), .RST(rst[g]), .Enable(en[g]), .Recenter(rc[g]),
      .Readable(rd[g]), .Up(bu[g]), .Down(bd[g]), .Left(bl[g]), .Right(br[g]),
      .X(xs[g]), .Y(ys[g]), .Tick(tk[g]), .Moving(mv[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle Readable pulse carrying the given buttons
  task automatic press(input int i, input logic u, input logic d, input logic l, input logic r);
    rd[i] = 1'b1; bu[i] = u; bd[i] = d; bl[i] = l; br[i] = r;
    @(negedge clk);
    rd[i] = 1'b0;
  endtask

  // Advance to the negedge where Tick is high, bounded to 20 cycles
  task automatic wait_tick(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tk[i] !== 1'b1 && n < 20);
    chk("tick_seen", 32'(tk[i]), 1);
  endtask

  initial begin
    int seen;
    rst = '1; en = '0; rc = '0; rd = '0; bu = '0; bd = '0; bl = '0; br = '0;
    en[0] = 1'b1;
    cyc(2);
    chk("rst_x",    xs[0], 320);
    chk("rst_y",    ys[0], 240);
    chk("rst_tick", 32'(tk[0]), 0);
    chk("rst_mov",  32'(mv[0]), 0);
    chk("rst_x_d",  xs[1], 636);
    chk("rst_y_b",  ys[2], 1);
    rst = '0;

    // First tick lands on the 4th edge after reset release
    cyc(3);
    chk("pre_tick", 32'(tk[0]), 0);
    cyc(1);
    chk("first_tick", 32'(tk[0]), 1);
    chk("first_tick_x", xs[0], 320);

    // Up+Down cancel, Left moves
    press(0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_tick(0);
    chk("opp_x1", xs[0], 319);
    chk("opp_y1", ys[0], 240);
    chk("opp_mov", 32'(mv[0]), 1);
    wait_tick(0);
    chk("opp_x2", xs[0], 318);
    chk("opp_y2", ys[0], 240);

    // Enable low: no ticks, position frozen
    en[0] = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tk[0] === 1'b1) seen = 1;
    end
    chk("dis_tick", seen, 0);
    chk("dis_x", xs[0], 318);
    chk("dis_y", ys[0], 240);

    // Recenter on the tick cycle wins and suppresses Tick
    en[0] = 1'b1;
    cyc(3);
    rc[0] = 1'b1;
    cyc(1);
    rc[0] = 1'b0;
    chk("rc_tick", 32'(tk[0]), 0);
    chk("rc_x", xs[0], 320);
    chk("rc_y", ys[0], 240);
    chk("rc_mov", 32'(mv[0]), 1);

    // Readable with Left on a tick cycle; Right was latched before
    press(0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(2);
    rd[0] = 1'b1; bl[0] = 1'b1; br[0] = 1'b0;
    cyc(1);
    rd[0] = 1'b0;
    chk("col_tick", 32'(tk[0]), 1);
    chk("col_x1", xs[0], 321);
    wait_tick(0);
    chk("col_x2", xs[0], 320);
    wait_tick(0);
    chk("col_x3", xs[0], 319);

    // Reset on a tick cycle discards the move and clears the latch
    cyc(3);
    rst[0] = 1'b1;
    cyc(1);
    rst[0] = 1'b0;
    chk("mrst_x", xs[0], 320);
    chk("mrst_y", ys[0], 240);
    chk("mrst_tick", 32'(tk[0]), 0);
    chk("mrst_mov", 32'(mv[0]), 0);
    wait_tick(0);
    chk("mrst_x2", xs[0], 320);
    chk("mrst_mov2", 32'(mv[0]), 0);

    // Right clamp from X=636
    press(1, 1'b0, 1'b0, 1'b0, 1'b1);
    en[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_tick(1);
      chk("clamp_x", xs[1], (636 + k > 639) ? 639 : 636 + k);
      chk("clamp_mov", 32'(mv[1]), (k <= 3) ? 1 : 0);
    end
    chk("clamp_y", ys[1], 240);

    // Wrap with STEP=3: Y=1 up -> 478, X=638 right -> 1
    press(2, 1'b1, 1'b0, 1'b0, 1'b1);
    en[2] = 1'b1;
    wait_tick(2);
    chk("wrap_x", xs[2], 1);
    chk("wrap_y", ys[2], 478);
    chk("wrap_mov", 32'(mv[2]), 1);

    // Hold Right from X=100, release, press again
    press(3, 1'b0, 1'b0, 1'b0, 1'b1);
    en[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_tick(3);
      chk("hold_x", xs[3], HOLD_X[k]);
    end
    press(3, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_tick(3);
    chk("rel_x", xs[3], HOLD_X[5]);
    chk("rel_mov", 32'(mv[3]), 0);
    press(3, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_tick(3);
    chk("repress_x1", xs[3], HOLD_X[5] + 1);
    wait_tick(3);
    chk("repress_x2", xs[3], HOLD_X[5] + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
